// File: rtl/mvm_pkg.sv
// Shared types and helpers for the MVM result buffer.
package mvm_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Wait counter width covers latencies up to 7 cycles.
  localparam int unsigned WAIT_CNT_W = 3;

  // Result word width for a given operand width.
  function automatic int unsigned result_width(input int unsigned b);
    return 2 * b;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO holding tagged result words.
module result_fifo #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned DEPTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when accompanied by a pop.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/mvm_result_buffer.sv
// Captures a k-word MVM result burst after a fixed latency and buffers it.
module mvm_result_buffer
  import mvm_pkg::*;
#(
  parameter int unsigned k    = 5,
  parameter int unsigned b    = 11,
  parameter int unsigned LAT  = 1,
  parameter int unsigned NVEC = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             done_in,
  input  logic [result_width(b)-1:0]       data_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [result_width(b)-1:0]       data_out,
  output logic                             out_last,
  output logic                             busy,
  output logic                             overflow
);

  localparam int unsigned RW    = result_width(b);
  localparam int unsigned DEPTH = NVEC * k;
  localparam int unsigned IW    = (k > 1) ? $clog2(k) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [IW-1:0]         elem_idx;

  logic                  sample;
  logic                  last_elem;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [RW:0]           head;

  // The WAIT cycle whose counter reads 0 is the first sample cycle, which
  // places element 0 exactly LAT cycles after done_in.
  assign sample    = (state == ST_CAPTURE) || ((state == ST_WAIT) && (wait_cnt == '0));
  assign last_elem = (elem_idx == IW'(k - 1));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_ready && !fifo_empty;
  assign drop      = sample && fifo_full && !pop;
  assign busy      = (state != ST_IDLE);
  assign data_out  = head[RW-1:0];
  assign out_last  = head[RW];

  // Capture sequencing, element indexing and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      elem_idx <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop || (done_in && (state != ST_IDLE))) begin
        overflow <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (done_in) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_CNT_W'(LAT - 1);
            elem_idx <= '0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end
        end
        ST_CAPTURE: ;
        default: state <= ST_IDLE;
      endcase
      if (sample) begin
        if (last_elem) begin
          state    <= ST_IDLE;
          elem_idx <= '0;
        end else begin
          state    <= ST_CAPTURE;
          elem_idx <= elem_idx + IW'(1);
        end
      end
    end
  end

  // Word storage; the tag bit marks the final element of a vector.
  result_fifo #(
    .WIDTH (RW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (sample),
    .push_data ({last_elem, data_in}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mvm_result_buffer.sv
// Scoreboard bench for mvm_result_buffer (LAT=1 and LAT=3 instances).
module tb_mvm_result_buffer;

  localparam int unsigned K = 5;
  localparam int unsigned B = 11;
  localparam int unsigned W = 2 * B;

  logic         clk = 1'b0;
  logic         reset;
  logic         done_in, out_ready;
  logic [W-1:0] data_in;
  logic         out_valid, out_last, busy, overflow;
  logic [W-1:0] data_out;

  logic         done_in_b, out_ready_b;
  logic [W-1:0] data_in_b;
  logic         out_valid_b, out_last_b, busy_b, overflow_b;
  logic [W-1:0] data_out_b;

  int vectors = 0;
  int miscompares = 0;
  logic [W:0] expq[$];
  logic [W:0] expq_b[$];

  always #5 clk = ~clk;

  mvm_result_buffer #(.k(K), .b(B), .LAT(1), .NVEC(2)) dut_a (
    .clk(clk), .reset(reset), .done_in(done_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  mvm_result_buffer #(.k(K), .b(B), .LAT(3), .NVEC(2)) dut_b (
    .clk(clk), .reset(reset), .done_in(done_in_b), .data_in(data_in_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .data_out(data_out_b),
    .out_last(out_last_b), .busy(busy_b), .overflow(overflow_b)
  );

  task automatic check_word(input string name, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got last=%0b data=%h, expected last=%0b data=%h",
               name, act[W], act[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: compare every accepted head word against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word_a: got last=%0b data=%h, expected none", out_last, data_out);
      end else begin
        check_word("word_a", {out_last, data_out}, expq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_b && out_ready_b) begin
      if (expq_b.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word_b: got last=%0b data=%h, expected none", out_last_b, data_out_b);
      end else begin
        check_word("word_b", {out_last_b, data_out_b}, expq_b.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    done_in = 1'b0;
    done_in_b = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One LAT=1 burst on dut_a: optional second done_in and ready release by element index.
  task automatic burst(input int vals[5], input bit keep, input int redo_idx, input int release_idx);
    done_in = 1'b1;
    data_in = '0;
    tick();
    done_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = W'(vals[i]);
      if (i == redo_idx) done_in = 1'b1;
      if (i == release_idx) out_ready = 1'b1;
      if (keep) expq.push_back({(i == 4), W'(vals[i])});
      tick();
      done_in = 1'b0;
    end
    data_in = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 100; c++) begin
      if (expq.size() == 0 && !out_valid) break;
      tick();
    end
    check_int(name, expq.size(), 0);
    check_bit({name, "_valid_low"}, out_valid, 1'b0);
  endtask

  initial begin
    int v[5];
    reset = 1'b1;
    done_in = 1'b0;
    data_in = '0;
    out_ready = 1'b0;
    done_in_b = 1'b0;
    data_in_b = '0;
    out_ready_b = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check_bit("reset_valid", out_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_overflow", overflow, 1'b0);
    check_bit("reset_valid_b", out_valid_b, 1'b0);

    // Basic burst with LAT=1 and timing of first valid.
    out_ready = 1'b1;
    tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    check_bit("wait_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      data_in = W'(i + 1);
      expq.push_back({(i == 4), W'(i + 1)});
      if (i == 0) check_bit("valid_not_same_cycle", out_valid, 1'b0);
      tick();
      if (i == 0) check_bit("valid_next_cycle", out_valid, 1'b1);
    end
    data_in = '0;
    check_bit("basic_busy_done", busy, 1'b0);
    wait_drain("drain_basic");
    check_bit("basic_overflow", overflow, 1'b0);

    // Backpressure: two vectors held, third dropped.
    out_ready = 1'b0;
    v = '{10, 11, 12, 13, 14}; burst(v, 1'b1, -1, -1); tick(); tick();
    v = '{20, 21, 22, 23, 24}; burst(v, 1'b1, -1, -1); tick(); tick();
    check_bit("full_no_overflow_yet", overflow, 1'b0);
    v = '{30, 31, 32, 33, 34}; burst(v, 1'b0, -1, -1); tick();
    check_bit("drop_overflow", overflow, 1'b1);
    check_bit("held_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    wait_drain("drain_backpressure");
    check_bit("overflow_sticky", overflow, 1'b1);

    do_reset();
    check_bit("overflow_cleared", overflow, 1'b0);

    // done_in repeated during CAPTURE.
    out_ready = 1'b1;
    v = '{41, 42, 43, 44, 45}; burst(v, 1'b1, 2, -1);
    tick();
    check_bit("redo_busy", busy, 1'b0);
    wait_drain("drain_redo");
    check_bit("redo_overflow", overflow, 1'b1);

    do_reset();

    // Full FIFO with simultaneous push and pop throughout capture.
    out_ready = 1'b0;
    v = '{50, 51, 52, 53, 54}; burst(v, 1'b1, -1, -1); tick();
    v = '{60, 61, 62, 63, 64}; burst(v, 1'b1, -1, -1); tick();
    v = '{70, 71, 72, 73, 74}; burst(v, 1'b1, -1, 0);
    wait_drain("drain_fullpass");
    check_bit("fullpass_overflow", overflow, 1'b0);

    // Reset during the third capture cycle discards the partial burst.
    out_ready = 1'b0;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    data_in = W'(1); tick();
    data_in = W'(2); tick();
    data_in = W'(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_in = '0;
    check_bit("abort_valid", out_valid, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    out_ready = 1'b1;
    tick();
    v = '{-3, -2, -1, 0, 7}; burst(v, 1'b1, -1, -1);
    wait_drain("drain_signed");
    check_bit("signed_overflow", overflow, 1'b0);

    // LAT=3: only words from done_in+3 onward are captured.
    done_in_b = 1'b1;
    tick();
    done_in_b = 1'b0;
    data_in_b = W'(99); tick();
    data_in_b = W'(98); tick();
    for (int i = 0; i < 5; i++) begin
      data_in_b = W'(i + 1);
      expq_b.push_back({(i == 4), W'(i + 1)});
      tick();
    end
    data_in_b = '0;
    for (int c = 0; c < 50; c++) begin
      if (expq_b.size() == 0 && !out_valid_b) break;
      tick();
    end
    check_int("drain_lat3", expq_b.size(), 0);
    check_bit("lat3_overflow", overflow_b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
